// File: rtl/iter_divider_pkg.sv
// ============================================================================
// Module : iter_divider_pkg
// Brief  : Shared FSM encoding and latency constant for the iterative divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package iter_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 32;

  function automatic int div_latency(input int width);
    return width + 1;
  endfunction

  // Stall length the pipeline must apply for a non-zero-divisor DIV.
  localparam int DIV_LATENCY = div_latency(DIV_WIDTH);

endpackage

`default_nettype wire

// File: rtl/iter_divider_div_step.sv
// ============================================================================
// Module : iter_divider_div_step
// Brief  : One combinational restoring-division iteration on {A,Q} against M.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH+1:0] w_a_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;

  // One extra guard bit keeps the trial difference sign unambiguous.
  assign w_a_sh = {i_a, i_q[WIDTH-1]};
  assign w_diff = w_a_sh - {2'b00, i_m};
  assign w_neg  = w_diff[WIDTH+1];

  assign o_a = w_neg ? w_a_sh[WIDTH:0] : w_diff[WIDTH:0];
  assign o_q = {i_q[WIDTH-2:0], ~w_neg};

endmodule

`default_nettype wire

// File: rtl/iter_divider.sv
// ============================================================================
// Module : iter_divider
// Brief  : Multi-cycle signed restoring divider with start/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             ready,
  output logic             busy
);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_exception;
  logic             r_ready;

  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic             w_div_zero;
  logic             w_last;

  // Magnitudes are unsigned WIDTH-bit, so |MIN_INT| stays representable.
  assign w_abs_dvd  = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_abs_dvs  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  iter_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_m (r_m),
    .o_a (w_a_nxt),
    .o_q (w_q_nxt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_div_zero ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_nxt = ST_FIX;
        end
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_exception <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // A zeroed working quotient makes the divide-by-zero result 0/0.
            r_q      <= w_div_zero ? '0 : w_abs_dvd;
            r_m      <= w_abs_dvs;
            r_a      <= '0;
            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividend[WIDTH-1];
            r_dz     <= w_div_zero;
            r_cnt    <= '0;
          end
        end
        ST_CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          r_quotient  <= r_sign_q ? -r_q : r_q;
          r_remainder <= r_sign_r ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
          r_exception <= r_dz;
          r_ready     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign exception = r_exception;
  assign ready     = r_ready;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
// Module : tb_iter_divider
// Brief  : Self-checking bench for iter_divider against a signed-arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iter_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         exception;
  logic         ready;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  iter_divider #(
    .WIDTH (W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .exception (exception),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference: plain signed division on 64-bit integers, truncated to W bits.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic e, output int lat);
    longint sa, sb, tq, tr;
    if (b == '0) begin
      q = '0; r = '0; e = 1'b1; lat = 1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tq = sa / sb;
      tr = sa % sb;
      q = tq[W-1:0]; r = tr[W-1:0]; e = 1'b0; lat = W + 1;
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_ready(input int lat0, output int lat);
    lat = lat0;
    while (ready !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int lat);
    logic [W-1:0] eq, er;
    logic         ee;
    int           elat;
    model(a, b, eq, er, ee, elat);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_exc"}, 32'(exception), 32'(ee));
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    launch(a, b);
    wait_ready(0, lat);
    check_result(tag, a, b, lat);
  endtask

  initial begin
    int           lat;
    int           pulses;
    logic [W-1:0] ra, rb;

    repeat (2) tick();
    chk("rst_q", quotient, '0);
    chk("rst_r", remainder, '0);
    chk("rst_exc", 32'(exception), 32'(0));
    chk("rst_ready", 32'(ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    reset_n = 1'b1;
    tick();

    run_check("p100_7", 32'd100, 32'd7);
    tick();
    chk("pulse_ready", 32'(ready), 32'(0));
    chk("hold_q", quotient, 32'd14);
    chk("idle_busy", 32'(busy), 32'(0));

    run_check("m100_7", -32'sd100, 32'd7);
    tick();
    run_check("p100_m7", 32'd100, -32'sd7);
    tick();
    run_check("dz", 32'h1234_5678, 32'd0);
    tick();
    run_check("after_dz", 32'd9, 32'd3);
    tick();
    run_check("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    run_check("small", 32'd5, 32'd9);
    tick();

    // A second start while busy must be dropped.
    launch(32'd50, 32'd5);
    chk("busy_calc", 32'(busy), 32'(1));
    lat = 0;
    while (lat < 10) begin tick(); lat++; end
    dividend = 32'd1; divisor = 32'd1; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    wait_ready(lat, lat);
    check_result("ignored", 32'd50, 32'd5, lat);

    // Accepted in the ready cycle; old result must persist until its own FIX.
    launch(32'd8, 32'd2);
    chk("b2b_ready_low", 32'(ready), 32'(0));
    chk("b2b_hold_q", quotient, 32'd10);
    wait_ready(0, lat);
    check_result("b2b", 32'd8, 32'd2, lat);
    tick();

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = 32'($signed(5'($urandom_range(0, 31))));
        2: rb = (i % 8 == 2) ? 32'd0 : 32'($urandom_range(1, 1000));
        default: begin rb = $urandom >> $urandom_range(0, 31); ra = ra >> 4; end
      endcase
      run_check($sformatf("rnd%0d", i), ra, rb);
      tick();
      chk($sformatf("rnd%0d_pulse", i), 32'(ready), 32'(0));
    end

    run_check("pre_rst", 32'd100, 32'd7);
    tick();
    launch(32'd100, 32'd7);
    repeat (14) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_q", quotient, '0);
    chk("mid_rst_r", remainder, '0);
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ready", 32'(ready), 32'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready === 1'b1) pulses++;
    end
    chk("no_pulse", 32'(pulses), 32'(0));
    run_check("post_rst", 32'd21, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
